// File: rtl/vga_timing_ctrl.sv
// 640x480@60 raster timing generator: waits for a stable PLL lock, then produces
// registered sx/sy counters, syncs, data-enable and line/frame strobes.
module vga_timing_ctrl #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter bit SYNC_POL      = 1'b0,
    parameter int SETTLE_CYCLES = 1024,
    parameter int CW            = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_clk_lock,
    output logic [CW-1:0] sx,
    output logic [CW-1:0] sy,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          line_start,
    output logic          frame_start,
    output logic          running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SW      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [CW-1:0] sx_q, sx_d, sy_q, sy_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic          running_q, running_d;
    logic          go_run;
    logic [CW-1:0] nx, ny;

    always_comb begin
        state_d       = state_q;
        settle_d      = settle_q;
        go_run        = 1'b0;
        nx            = '0;
        ny            = '0;
        sx_d          = '0;
        sy_d          = '0;
        hsync_d       = ~SYNC_POL;
        vsync_d       = ~SYNC_POL;
        de_d          = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        running_d     = 1'b0;

        case (state_q)
            WAIT_LOCK: begin
                settle_d = '0;
                if (pix_clk_lock) state_d = SETTLE;
            end
            SETTLE: begin
                if (!pix_clk_lock) begin
                    state_d  = WAIT_LOCK;
                    settle_d = '0;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d  = RUN;
                    settle_d = '0;
                    go_run   = 1'b1;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            RUN: begin
                // A lock drop abandons the frame immediately, even on a wrap cycle.
                if (!pix_clk_lock) begin
                    state_d = WAIT_LOCK;
                end else begin
                    go_run = 1'b1;
                    if (sx_q == H_LAST) begin
                        nx = '0;
                        ny = (sy_q == V_LAST) ? '0 : sy_q + CW'(1);
                    end else begin
                        nx = sx_q + CW'(1);
                        ny = sy_q;
                    end
                end
            end
            default: state_d = WAIT_LOCK;
        endcase

        // Outputs are decoded from the position about to be registered so they
        // stay aligned with sx/sy on the output pins.
        if (go_run) begin
            sx_d          = nx;
            sy_d          = ny;
            hsync_d       = (nx >= HS_START && nx < HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync_d       = (ny >= VS_START && ny < VS_END) ? SYNC_POL : ~SYNC_POL;
            de_d          = (nx < H_VIS) && (ny < V_VIS);
            line_start_d  = (nx == '0);
            frame_start_d = (nx == '0) && (ny == '0);
            running_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_LOCK;
            settle_q      <= '0;
            sx_q          <= '0;
            sy_q          <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_q      <= settle_d;
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            running_q     <= running_d;
        end
    end

    assign sx          = sx_q;
    assign sy          = sy_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign running     = running_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a lock-streak raster model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_vga_timing_ctrl;

    localparam int HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int VA = 12, VF = 2, VS = 2, VB = 4;
    localparam int N  = 4;
    localparam int HT = HA + HF + HS + HB;   // 800
    localparam int VT = VA + VF + VS + VB;   // 20
    localparam longint RUN_AT = N + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic [9:0] sx, sy;
    logic       hsync, vsync, de, line_start, frame_start, running;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    longint streak = 0;

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .SETTLE_CYCLES(N), .CW(10)
    ) dut (
        .clk(clk), .rst(rst), .pix_clk_lock(lock),
        .sx(sx), .sy(sy), .hsync(hsync), .vsync(vsync), .de(de),
        .line_start(line_start), .frame_start(frame_start), .running(running)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: the raster runs once N+1 consecutive clean locked edges have been seen;
    // the position is simply the number of edges elapsed since then.
    always @(posedge clk) begin
        if (rst || !lock) streak <= 0;
        else              streak <= streak + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            longint p, mx, my;
            bit     e_run, e_hs, e_vs, e_de, e_ls, e_fs;
            mx = 0; my = 0; e_run = 0; e_hs = 1; e_vs = 1; e_de = 0; e_ls = 0; e_fs = 0;
            if (streak >= RUN_AT) begin
                p     = streak - RUN_AT;
                mx    = p % HT;
                my    = (p / HT) % VT;
                e_run = 1;
                e_hs  = !(mx >= HA + HF && mx < HA + HF + HS);
                e_vs  = !(my >= VA + VF && my < VA + VF + VS);
                e_de  = (mx < HA) && (my < VA);
                e_ls  = (mx == 0);
                e_fs  = (mx == 0) && (my == 0);
            end
            check("sx", sx, mx);
            check("sy", sy, my);
            check("running", running, e_run);
            check("hsync", hsync, e_hs);
            check("vsync", vsync, e_vs);
            check("de", de, e_de);
            check("line_start", line_start, e_ls);
            check("frame_start", frame_start, e_fs);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_wait(input string nm, input int exp_edges);
        int n;
        int early;
        n = 0;
        early = 0;
        while (!running && n < 20) begin
            early += line_start + frame_start;
            step();
            n++;
        end
        check({nm, "_edges_to_run"}, n, exp_edges);
        check({nm, "_early_strobes"}, early, 0);
        check({nm, "_first_frame_start"}, frame_start, 1);
        check({nm, "_first_sx"}, sx, 0);
        check({nm, "_first_sy"}, sy, 0);
        check({nm, "_first_de"}, de, 1);
    endtask

    task automatic wait_pos(input string nm, input int x, input int y, input int budget);
        int n;
        n = 0;
        while (!(sx == 10'(x) && sy == 10'(y)) && n < budget) begin
            step();
            n++;
        end
        check({nm, "_reached"}, (sx == 10'(x) && sy == 10'(y)), 1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int strobes, idle_run;
        int lines, frames, hs_low, hs_starts, vs_low, vs_first_sy, de_cnt;

        // Reset and idle
        rst = 1'b1;
        lock = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        step();
        rst = 1'b0;
        strobes = 0;
        idle_run = 0;
        for (int i = 0; i < 100; i++) begin
            strobes += line_start + frame_start;
            idle_run += running;
            step();
        end
        check("idle_strobes", strobes, 0);
        check("idle_running", idle_run, 0);
        check("idle_hsync", hsync, 1);
        check("idle_vsync", vsync, 1);

        // Startup: lock high, first RUN output N+1 edges later
        lock = 1'b1;
        run_wait("startup", 5);

        // One full frame from this frame_start
        lines = 0; frames = 0; hs_low = 0; hs_starts = 0; vs_low = 0; de_cnt = 0;
        vs_first_sy = -1;
        for (int c = 0; c < HT * VT; c++) begin
            lines  += line_start;
            frames += frame_start;
            de_cnt += de;
            if (!hsync) hs_low++;
            if (!hsync && sx == 10'd656) hs_starts++;
            if (!vsync) begin
                vs_low++;
                if (vs_first_sy < 0) begin
                    vs_first_sy = int'(sy);
                    check("vsync_first_sx", sx, 0);
                end
            end
            step();
        end
        check("frame_lines", lines, 20);
        check("frame_starts_in_period", frames, 1);
        check("frame_period_next_start", frame_start, 1);
        check("hsync_low_cycles", hs_low, 96 * 20);
        check("hsync_starts_at_656", hs_starts, 20);
        check("vsync_low_cycles", vs_low, 1600);
        check("vsync_first_line", vs_first_sy, 14);
        check("de_cycles", de_cnt, 640 * 12);

        // Lock loss mid-frame
        wait_pos("lockloss", 300, 5, HT * VT);
        lock = 1'b0;
        step();
        check("lockloss_running", running, 0);
        check("lockloss_sx", sx, 0);
        check("lockloss_sy", sy, 0);
        check("lockloss_hsync", hsync, 1);
        lock = 1'b1;
        run_wait("relock", 5);

        // Lock drop coinciding with the end-of-frame wrap
        wait_pos("wrapdrop", 799, 19, HT * VT + 10);
        lock = 1'b0;
        step();
        check("wrapdrop_running", running, 0);
        check("wrapdrop_frame_start", frame_start, 0);

        // Settle glitch: 3 locked, 1 unlocked, then a full settle again
        lock = 1'b1;
        idle_run = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            idle_run += running;
        end
        lock = 1'b0;
        step();
        idle_run += running;
        check("glitch_running", idle_run, 0);
        lock = 1'b1;
        run_wait("glitch", 5);

        // Reset mid-frame while both syncs are asserted, lock held high
        wait_pos("midreset", 700, 14, HT * VT);
        check("midreset_hsync_active", hsync, 0);
        check("midreset_vsync_active", vsync, 0);
        rst = 1'b1;
        step();
        check("midreset_hsync", hsync, 1);
        check("midreset_vsync", vsync, 1);
        check("midreset_de", de, 0);
        check("midreset_running", running, 0);
        rst = 1'b0;
        run_wait("after_reset", N + 1);

        repeat (10) step();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Sequences the 640x480@60 display datapath from the PLL-derived pixel clock.
- Holds the display idle until the PLL lock signal is stable for a settle period, then generates the horizontal and vertical counters, sync pulses, data-enable and frame/line strobes that the rectangle renderer consumes.
- Returns to idle on loss of lock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, pixel clocks
- H_SYNC, 96, horizontal sync width, pixel clocks
- H_BP, 48, horizontal back porch, pixel clocks
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, lines
- V_SYNC, 2, vertical sync width, lines
- V_BP, 33, vertical back porch, lines
- SYNC_POL, 0, sync active level (0 = active-low)
- SETTLE_CYCLES, 1024, consecutive locked cycles required before RUN (>=1)
- CW, 10, width of sx/sy counters

Ports:
- clk  input  1  pixel clock (PLL global output)
- rst  input  1  synchronous, active-high reset
- pix_clk_lock  input  1  PLL lock indication, level
- sx  output  CW  horizontal pixel position
- sy  output  CW  vertical line position
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- de  output  1  data enable (visible region)
- line_start  output  1  one-cycle pulse, sx==0
- frame_start  output  1  one-cycle pulse, sx==0 and sy==0
- running  output  1  high while in RUN

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst. All outputs are registered.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Idle output values (reset, WAIT_LOCK, SETTLE):
  - sx=0, sy=0, de=0, line_start=0, frame_start=0, running=0
  - hsync=vsync=~SYNC_POL (1 at default)
- States:
  - WAIT_LOCK (reset state): settle counter cleared. Go to SETTLE when pix_clk_lock=1.
  - SETTLE: settle counter increments each cycle while pix_clk_lock=1. If pix_clk_lock=0, go to WAIT_LOCK and clear the counter. When the counter reaches SETTLE_CYCLES-1 with lock still high, go to RUN.
  - RUN: running=1. If pix_clk_lock=0, go to WAIT_LOCK on the next edge; outputs go idle that same edge, with no partial-frame completion.
- Timing of RUN entry: the first RUN cycle presents pixel (0,0) with line_start=1, frame_start=1 and de=1. SETTLE_CYCLES=N with lock high from cycle t0 gives first RUN output at cycle t0+N+1.
- Counters in RUN:
  - sx increments every cycle and wraps from H_TOTAL-1 to 0.
  - sy increments when sx wraps, and wraps from V_TOTAL-1 to 0.
- Outputs in RUN (all same-cycle aligned with the sx/sy values presented):
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= sx < H_ACTIVE+H_FP+H_SYNC (656..751), else ~SYNC_POL.
  - vsync = SYNC_POL when V_ACTIVE+V_FP <= sy < V_ACTIVE+V_FP+V_SYNC (490..491), else ~SYNC_POL. vsync is line-based and changes only when sx==0.
  - de = (sx < H_ACTIVE) && (sy < V_ACTIVE).
  - line_start = (sx==0); frame_start = (sx==0 && sy==0).
- Simultaneous events:
  - rst dominates lock.
  - A lock drop on the same cycle as a wrap still goes to idle.
  - Lock re-asserted during WAIT_LOCK always restarts the full settle period.
- Reset mid-operation: the next edge forces idle values and WAIT_LOCK, whatever the state.
- Arithmetic: compare constants are computed at elaboration and must fit in CW bits; the counters never exceed TOTAL-1.

Test Plan:
- Reset/idle: rst=1 for 3 cycles, lock=0 -> sx=sy=0, de=0, hsync=vsync=1, running=0, no strobes for 100 cycles.
- Startup: SETTLE_CYCLES=4, lock rises at cycle 10 -> running=1 and frame_start=1 with sx=0, sy=0 at cycle 15; no earlier strobe.
- Full frame: run 420000 cycles -> period between frame_start pulses exactly 420000; line_start every 800; hsync low exactly 96 cycles per line, starting at sx=656; vsync low for exactly lines 490-491 (1600 cycles); de high 307200 cycles per frame.
- Settle glitch: SETTLE_CYCLES=4, lock high 3 cycles, low 1, then high -> RUN entered only after 4 further consecutive locked cycles.
- Lock loss mid-frame: drop lock at sx=300, sy=200 -> next cycle idle values, running=0; relock -> restart at (0,0) with frame_start after settle.
- Reset mid-frame: rst=1 at sx=700, sy=491 (hsync and vsync asserted) -> next cycle hsync=vsync=1, de=0, state WAIT_LOCK; with lock held high, RUN resumes after SETTLE_CYCLES+1 cycles.
